instruction_fetch_unit: RTL

Initiator side of the instruction-memory interface. It owns the PC and drives pc_address into the combinational instruction memory, which returns ir in the same cycle. Fetched words go into a small fetch queue and are handed to decode over a valid/ready handshake. The unit accepts branch/jump redirects, detects the end-of-program sentinel 32'hFFFFFFFF, and flags misaligned or out-of-range fetches.

---
 rtl/mips_if_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_queue.sv | 66 ++++++
 rtl/instruction_fetch_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mips_if_pkg.sv
// Shared types for the instruction fetch unit: sentinel value, fetch FSM
// states and the fetch queue entry layout.
// No logic; imported by fetch_queue and instruction_fetch_unit.
package mips_if_pkg;

  // End-of-program marker returned by instruction memory.
  localparam logic [31:0] IF_SENTINEL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// fetch_queue: QDEPTH-entry synchronous FIFO of fetch_entry_t.
// Latency: a push is visible at head the next cycle; head is read straight from storage.
// Backpressure: push is dropped when full unless a pop happens the same cycle;
// flush beats push.
// Ports: clk, reset (sync, active-high), push/push_data, pop, flush,
//        head (current oldest entry), count, full, empty.
module fetch_queue
  import mips_if_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(QDEPTH):0]    count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [QDEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            pop_ok;
  logic            push_ok;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full queue can still take a push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches from combinational IMEM into a
// small queue and hands words to decode over if_valid/if_ready.
// Latency: word fetched in cycle N is at the queue head in cycle N+1.
// Backpressure: when the queue is full and decode stalls, the PC holds.
// Ports: clk, reset (sync, active-high); pc_address/ir to IMEM;
//        redirect_valid/redirect_target from branch resolution;
//        if_valid/if_ready/if_instr/if_pc to decode; halted, fault, fault_pc status.
module instruction_fetch_unit
  import mips_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 8192,
  parameter int          QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_address,
  input  logic [31:0] ir,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;

  // One past the last legal byte address; 33 bits so large memories cannot wrap.
  localparam logic [32:0] PC_LIMIT = {1'b0, 32'(IMEM_WORDS)} << 2;

  fetch_state_t  state_q;
  logic [31:0]   pc_q;
  logic          halted_q;
  logic          fault_q;
  logic [31:0]   fault_pc_q;

  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic          q_push;
  logic          q_pop;
  logic          q_flush;

  logic          pc_legal;
  logic          is_sentinel;
  logic          redirect_bad;
  logic          drain_done;

  assign pc_address = pc_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_pc   = fault_pc_q;

  assign if_valid   = !q_empty && (state_q != FAULT);
  assign if_instr   = q_head.instr;
  assign if_pc      = q_head.pc;

  assign pc_legal     = ({1'b0, pc_q} < PC_LIMIT);
  assign is_sentinel  = (ir == IF_SENTINEL);
  assign redirect_bad = (redirect_target[1:0] != 2'b00);

  assign q_pop        = if_valid && if_ready;
  assign q_push_data  = '{pc: pc_q, instr: ir};

  // Queue is empty at the end of this cycle, counting any pop happening now.
  assign drain_done   = q_empty || ((q_count == CW'(1)) && q_pop);

  always_comb begin
    q_push  = 1'b0;
    q_flush = 1'b0;
    if (state_q != FAULT && redirect_valid) begin
      // Both good and misaligned redirects discard queued work.
      q_flush = 1'b1;
    end else if (state_q == RUN) begin
      if (!pc_legal) begin
        q_flush = 1'b1;
      end else if (!is_sentinel && (!q_full || q_pop)) begin
        q_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      case (state_q)
        RUN, DRAIN, HALT: begin
          if (redirect_valid) begin
            halted_q <= 1'b0;
            if (redirect_bad) begin
              state_q    <= FAULT;
              fault_q    <= 1'b1;
              fault_pc_q <= redirect_target;
            end else begin
              state_q <= RUN;
              pc_q    <= redirect_target;
            end
          end else begin
            case (state_q)
              RUN: begin
                // Range check precedes the sentinel test: ir is meaningless
                // for an address outside the memory.
                if (!pc_legal) begin
                  state_q    <= FAULT;
                  fault_q    <= 1'b1;
                  fault_pc_q <= pc_q;
                end else if (is_sentinel) begin
                  state_q <= DRAIN;
                end else if (q_push) begin
                  pc_q <= pc_q + 32'd4;
                end
              end
              DRAIN: begin
                if (drain_done) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
                end
              end
              default: begin
              end
            endcase
          end
        end
        default: begin
          // FAULT is terminal until reset.
        end
      endcase
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (q_flush),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule
